// File: rtl/hazard_pkg.sv
// ============================================================================
// Module : hazard_pkg
// Brief  : Opcode constants and watchdog state encoding for the hazard unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STALL   = 2'd1,
        TIMEOUT = 2'd2
    } wd_state_t;

endpackage

`default_nettype wire

// File: rtl/hazard_watchdog.sv
// ============================================================================
// Module : hazard_watchdog
// Brief  : Counts consecutive hazard cycles and raises a sticky timeout flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_watchdog
    import hazard_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hz,
    output logic timeout
);

    localparam int                 C_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [C_CNT_W-1:0] C_LIMIT = C_CNT_W'(TIMEOUT_CYCLES);
    localparam logic [C_CNT_W-1:0] C_ONE   = C_CNT_W'(1);

    wd_state_t          r_state;
    wd_state_t          w_state_nxt;
    logic [C_CNT_W-1:0] r_count;
    logic [C_CNT_W-1:0] w_count_nxt;
    logic               r_timeout;
    logic               w_timeout_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // The count holds the number of consecutive hazard cycles already closed
    // by a clock edge, so the limit check uses the post-increment value.
    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_timeout_nxt = r_timeout;
        case (r_state)
            IDLE: begin
                if (hz) begin
                    w_count_nxt = C_ONE;
                    if (C_LIMIT == C_ONE) begin
                        w_state_nxt   = TIMEOUT;
                        w_timeout_nxt = 1'b1;
                    end else begin
                        w_state_nxt = STALL;
                    end
                end
            end
            STALL: begin
                if (!hz) begin
                    w_state_nxt = IDLE;
                    w_count_nxt = '0;
                end else begin
                    w_count_nxt = r_count + C_ONE;
                    if (w_count_nxt == C_LIMIT) begin
                        w_state_nxt   = TIMEOUT;
                        w_timeout_nxt = 1'b1;
                    end
                end
            end
            TIMEOUT: begin
                if (!hz) begin
                    w_state_nxt = IDLE;
                    w_count_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    assign timeout = r_timeout;

endmodule

`default_nettype wire

// File: rtl/hazard_stall_controller.sv
// ============================================================================
// Module : hazard_stall_controller
// Brief  : Memory/control hazard stalls, flush sequencer, stall watchdogs and
//          optional perf counters (enabled by HAZARD_PERF_COUNTERS_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_stall_controller
    import hazard_pkg::*;
#(
    parameter int CORE           = 0,
    parameter int ADDRESS_BITS   = 20,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int FLUSH_CYCLES   = 2,
    parameter int COUNTER_BITS   = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    fetch_valid,
    input  logic                    fetch_ready,
    input  logic                    issue_request,
    input  logic [ADDRESS_BITS-1:0] issue_PC,
    input  logic [ADDRESS_BITS-1:0] fetch_address_in,
    input  logic                    memory_valid,
    input  logic                    memory_ready,
    input  logic                    load_memory,
    input  logic                    store_memory,
    input  logic [ADDRESS_BITS-1:0] load_address,
    input  logic [ADDRESS_BITS-1:0] memory_address_in,
    input  logic [6:0]              opcode_decode,
    input  logic [6:0]              opcode_execute,
    input  logic                    branch_execute,
    output logic                    stall_fetch,
    output logic                    stall_memory,
    output logic                    flush_decode,
    output logic                    flush_execute,
    output logic                    i_timeout,
    output logic                    d_timeout,
    output logic [COUNTER_BITS-1:0] i_stall_count,
    output logic [COUNTER_BITS-1:0] d_stall_count,
    output logic [COUNTER_BITS-1:0] flush_count
);

    localparam int                  C_FCNT_W    = $clog2(FLUSH_CYCLES + 1);
    localparam logic [C_FCNT_W-1:0] C_FLUSH_LD  = C_FCNT_W'(FLUSH_CYCLES - 1);
    localparam logic [31:0]         C_CORE_ID   = 32'(CORE);

    logic                w_i_hz;
    logic                w_d_hz;
    logic                w_jb;
    logic                w_jal;
    logic                w_accept;
    logic                w_fcnt_busy;
    logic [C_FCNT_W-1:0] r_fcnt;
    logic                r_ftype;
    logic                w_unused;

    // Stores never wait on returned data; the core id is a debug tag only.
    assign w_unused = ^{store_memory, C_CORE_ID};

    assign w_i_hz = (~fetch_ready & ~issue_request)
                  | (issue_request & (~fetch_valid | (issue_PC != fetch_address_in)));
    assign w_d_hz = ~memory_ready
                  | (load_memory & (~memory_valid | (load_address != memory_address_in)));

    assign w_jb  = (opcode_execute == JALR) | ((opcode_execute == BRANCH) & branch_execute);
    assign w_jal = (opcode_decode == JAL);

    assign w_accept    = ~w_d_hz;
    assign w_fcnt_busy = (r_fcnt != '0);

    // Combinational outputs are masked so nothing leaks out while in reset.
    assign stall_memory  = rst_n & w_d_hz;
    assign stall_fetch   = rst_n & (w_i_hz | w_d_hz);
    assign flush_decode  = rst_n & (w_jb | w_jal | w_fcnt_busy);
    assign flush_execute = rst_n & (w_jb | (w_fcnt_busy & r_ftype));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fcnt  <= '0;
            r_ftype <= 1'b0;
        end else if (w_accept) begin
            if (w_jb) begin
                r_fcnt  <= C_FLUSH_LD;
                r_ftype <= 1'b1;
            end else if (w_jal) begin
                r_fcnt  <= '0;
                r_ftype <= 1'b0;
            end else if (w_fcnt_busy) begin
                r_fcnt <= r_fcnt - C_FCNT_W'(1);
            end
        end
    end

    hazard_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_i_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .hz      (w_i_hz),
        .timeout (i_timeout)
    );

    hazard_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_d_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .hz      (w_d_hz),
        .timeout (d_timeout)
    );

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [COUNTER_BITS-1:0] r_i_stall_count;
    logic [COUNTER_BITS-1:0] r_d_stall_count;
    logic [COUNTER_BITS-1:0] r_flush_count;
    logic                    w_flush_event;

    assign w_flush_event = w_accept & (w_jb | w_jal);

    // Saturating counters: they stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i_stall_count <= '0;
            r_d_stall_count <= '0;
            r_flush_count   <= '0;
        end else begin
            if (w_i_hz && (r_i_stall_count != '1)) begin
                r_i_stall_count <= r_i_stall_count + COUNTER_BITS'(1);
            end
            if (w_d_hz && (r_d_stall_count != '1)) begin
                r_d_stall_count <= r_d_stall_count + COUNTER_BITS'(1);
            end
            if (w_flush_event && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + COUNTER_BITS'(1);
            end
        end
    end

    assign i_stall_count = r_i_stall_count;
    assign d_stall_count = r_d_stall_count;
    assign flush_count   = r_flush_count;
`else
    assign i_stall_count = '0;
    assign d_stall_count = '0;
    assign flush_count   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_controller.sv
// ============================================================================
// Module : tb_hazard_stall_controller
// Brief  : Directed self-checking bench for hazard_stall_controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hazard_stall_controller;
    import hazard_pkg::*;

    localparam int AB = 20;
    localparam int CB = 4;
`ifdef HAZARD_PERF_COUNTERS_EN
    localparam bit C_PERF = 1'b1;
`else
    localparam bit C_PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fetch_valid, fetch_ready, issue_request;
    logic [AB-1:0] issue_PC, fetch_address_in;
    logic          memory_valid, memory_ready, load_memory, store_memory;
    logic [AB-1:0] load_address, memory_address_in;
    logic [6:0]    opcode_decode, opcode_execute;
    logic          branch_execute;
    logic          stall_fetch, stall_memory, flush_decode, flush_execute;
    logic          i_timeout, d_timeout;
    logic [CB-1:0] i_stall_count, d_stall_count, flush_count;

    int checks = 0;
    int errors = 0;

    hazard_stall_controller #(
        .CORE           (0),
        .ADDRESS_BITS   (AB),
        .TIMEOUT_CYCLES (255),
        .FLUSH_CYCLES   (3),
        .COUNTER_BITS   (CB)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .fetch_valid       (fetch_valid),
        .fetch_ready       (fetch_ready),
        .issue_request     (issue_request),
        .issue_PC          (issue_PC),
        .fetch_address_in  (fetch_address_in),
        .memory_valid      (memory_valid),
        .memory_ready      (memory_ready),
        .load_memory       (load_memory),
        .store_memory      (store_memory),
        .load_address      (load_address),
        .memory_address_in (memory_address_in),
        .opcode_decode     (opcode_decode),
        .opcode_execute    (opcode_execute),
        .branch_execute    (branch_execute),
        .stall_fetch       (stall_fetch),
        .stall_memory      (stall_memory),
        .flush_decode      (flush_decode),
        .flush_execute     (flush_execute),
        .i_timeout         (i_timeout),
        .d_timeout         (d_timeout),
        .i_stall_count     (i_stall_count),
        .d_stall_count     (d_stall_count),
        .flush_count       (flush_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle;
        fetch_valid       = 1'b0;
        fetch_ready       = 1'b1;
        issue_request     = 1'b0;
        issue_PC          = '0;
        fetch_address_in  = '0;
        memory_valid      = 1'b0;
        memory_ready      = 1'b1;
        load_memory       = 1'b0;
        store_memory      = 1'b0;
        load_address      = '0;
        memory_address_in = '0;
        opcode_decode     = R_TYPE;
        opcode_execute    = R_TYPE;
        branch_execute    = 1'b0;
    endtask

    function automatic logic [31:0] perf(input int n);
        return C_PERF ? 32'(n) : 32'd0;
    endfunction

    initial begin
        #100000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit expired");
    end

    initial begin
        rst_n = 1'b0;
        set_idle();
        memory_ready   = 1'b0;
        fetch_ready    = 1'b0;
        opcode_execute = JALR;
        repeat (2) tick();
        check("rst_stall_memory", stall_memory, 0);
        check("rst_stall_fetch", stall_fetch, 0);
        check("rst_flush_decode", flush_decode, 0);
        check("rst_flush_execute", flush_execute, 0);
        check("rst_i_timeout", i_timeout, 0);
        check("rst_d_timeout", d_timeout, 0);
        check("rst_i_count", i_stall_count, 0);
        check("rst_d_count", d_stall_count, 0);
        check("rst_flush_count", flush_count, 0);

        opcode_execute = R_TYPE;
        rst_n = 1'b1;
        #1;
        check("rel_stall_memory", stall_memory, 1);
        check("rel_stall_fetch", stall_fetch, 1);
        repeat (3) tick();
        set_idle();
        #1;
        check("idle_stall_fetch", stall_fetch, 0);
        check("idle_stall_memory", stall_memory, 0);
        check("i_count_3", i_stall_count, perf(3));
        check("d_count_3", d_stall_count, perf(3));

        // Fetch hazard vectors: each applied mid-cycle, idle again before the edge.
        tick();
        issue_request = 1'b1; fetch_valid = 1'b1; issue_PC = 20'h00123; fetch_address_in = 20'h00123;
        #1; check("if_match", stall_fetch, 0);
        set_idle(); tick();
        issue_request = 1'b1; fetch_valid = 1'b1; issue_PC = 20'h00123; fetch_address_in = 20'h00124;
        #1; check("if_addr_mismatch", stall_fetch, 1);
        check("if_mismatch_no_dstall", stall_memory, 0);
        set_idle(); tick();
        issue_request = 1'b1; fetch_valid = 1'b0; issue_PC = 20'h00123; fetch_address_in = 20'h00123;
        #1; check("if_not_valid", stall_fetch, 1);
        set_idle(); tick();
        load_memory = 1'b1; memory_valid = 1'b1; load_address = 20'h00055; memory_address_in = 20'h00055;
        #1; check("ld_match", stall_memory, 0);
        set_idle(); tick();
        load_memory = 1'b1; memory_valid = 1'b1; load_address = 20'h00055; memory_address_in = 20'h00056;
        #1; check("ld_addr_mismatch", stall_memory, 1);
        check("ld_mismatch_fetch", stall_fetch, 1);
        set_idle(); tick();
        load_memory = 1'b1; memory_valid = 1'b0; load_address = 20'h00055; memory_address_in = 20'h00055;
        #1; check("ld_not_valid", stall_memory, 1);
        set_idle(); tick();

        // Data-side counter saturation at 2^CB-1 = 15.
        memory_ready = 1'b0;
        repeat (11) tick();
        check("d_count_14", d_stall_count, perf(14));
        tick();
        check("d_count_15", d_stall_count, perf(15));
        tick();
        check("d_count_sat", d_stall_count, perf(15));
        check("d_no_timeout", d_timeout, 0);
        set_idle(); tick();

        // Fetch watchdog: 255 consecutive hazard cycles.
        issue_request = 1'b1; fetch_valid = 1'b0;
        repeat (254) tick();
        check("i_timeout_254", i_timeout, 0);
        tick();
        check("i_timeout_255", i_timeout, 1);
        set_idle(); tick();
        check("i_timeout_sticky", i_timeout, 1);
        check("i_count_sat", i_stall_count, perf(15));
        check("d_timeout_clear", d_timeout, 0);

        // JALR flush, unstalled: exactly 3 cycles.
        opcode_execute = JALR;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("jalr_fd_%0d", i), flush_decode, (i < 3) ? 1 : 0);
            check($sformatf("jalr_fe_%0d", i), flush_execute, (i < 3) ? 1 : 0);
            tick();
            opcode_execute = R_TYPE;
        end
        check("flush_count_1", flush_count, perf(1));

        // JALR with memory stalled in cycles 1..3: flush frozen, lasts 6 cycles.
        for (int i = 0; i < 7; i++) begin
            opcode_execute = (i == 0) ? JALR : R_TYPE;
            memory_ready   = (i >= 1 && i <= 3) ? 1'b0 : 1'b1;
            #1;
            check($sformatf("stl_fd_%0d", i), flush_decode, (i < 6) ? 1 : 0);
            check($sformatf("stl_fe_%0d", i), flush_execute, (i < 6) ? 1 : 0);
            tick();
        end
        set_idle();
        check("flush_count_2", flush_count, perf(2));

        // JAL together with taken branch behaves as a branch flush.
        opcode_decode = JAL; opcode_execute = BRANCH; branch_execute = 1'b1;
        #1;
        check("jalbr_fd_0", flush_decode, 1);
        check("jalbr_fe_0", flush_execute, 1);
        tick(); set_idle(); #1;
        check("jalbr_fe_1", flush_execute, 1);
        tick(); tick();
        check("jalbr_fd_3", flush_decode, 0);
        check("jalbr_fe_3", flush_execute, 0);
        check("flush_count_3", flush_count, perf(3));

        // JAL alone: single-cycle decode flush only.
        opcode_decode = JAL;
        #1;
        check("jal_fd_0", flush_decode, 1);
        check("jal_fe_0", flush_execute, 0);
        tick(); set_idle(); #1;
        check("jal_fd_1", flush_decode, 0);
        check("flush_count_4", flush_count, perf(4));

        // Branch not taken: no flush.
        opcode_execute = BRANCH; branch_execute = 1'b0;
        #1;
        check("bnt_fd", flush_decode, 0);
        check("bnt_fe", flush_execute, 0);
        set_idle(); tick();

        // JALR while stalled is shown but not accepted.
        opcode_execute = JALR; memory_ready = 1'b0;
        #1;
        check("jalr_stalled_fd", flush_decode, 1);
        tick(); set_idle(); #1;
        check("jalr_stalled_fd_next", flush_decode, 0);
        check("jalr_stalled_fe_next", flush_execute, 0);
        check("flush_count_still_4", flush_count, perf(4));

        // Reset in the middle of a flush.
        opcode_execute = JALR;
        tick(); set_idle(); #1;
        check("midrst_fd_before", flush_decode, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_fd", flush_decode, 0);
        check("midrst_fe", flush_execute, 0);
        check("midrst_i_timeout", i_timeout, 0);
        check("midrst_flush_count", flush_count, 0);
        tick();
        rst_n = 1'b1;
        #1;
        check("post_rst_fd", flush_decode, 0);
        check("post_rst_fe", flush_execute, 0);
        tick();
        check("post_rst_fd_next", flush_decode, 0);
        check("post_rst_i_timeout", i_timeout, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
